dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter in front of a single-port synchronous data SRAM.
// m0 is the CPU data port and m1 is the debug/loader port. When both masters
// request in ARB, round-robin picks between them. m1 can take exclusive
// ownership (LOCK). Accepted requests become registered SRAM pins one cycle
// later. Read data returns to the issuing master two cycles after acceptance.

module dmem_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_stall,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_stall,

    output logic              CEN,
    output logic              WEN,
    output logic              OEN,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] Data2Mem,
    input  logic [DATA_W-1:0] ReadDataMem
);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    // 1: m1 was granted most recently, so m0 wins the next contention.
    logic                r_last;
    logic                w_last_nxt;

    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_acc;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    logic                r_cen;
    logic                r_wen;
    logic                r_oen;
    logic [ADDR_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_d;

    logic                r_vld_p1;
    logic                r_vld_p2;
    logic                r_own_p1;
    logic                r_own_p2;
    logic                w_rvalid0;
    logic                w_rvalid1;

    // State and round-robin pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_ARB;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next state. The pointer follows accepted requests. Leaving LOCK hands priority back to m0.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        if (w_acc) begin
            w_last_nxt = w_gnt1;
        end
        case (r_state)
            ST_ARB: begin
                if (w_gnt1 && m1_lock) begin
                    w_state_nxt = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (!m1_lock) begin
                    w_state_nxt = ST_ARB;
                    w_last_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase
    end

    // Grant decode. Grants use the current requests and the registered state, and are forced low in reset.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_ARB: begin
                    if (m0_req && m1_req) begin
                        w_gnt0 = r_last;
                        w_gnt1 = ~r_last;
                    end else begin
                        w_gnt0 = m0_req;
                        w_gnt1 = m1_req;
                    end
                end
                ST_LOCK: begin
                    w_gnt1 = m1_req;
                end
                default: begin
                    w_gnt0 = 1'b0;
                    w_gnt1 = 1'b0;
                end
            endcase
        end
    end

    assign w_acc       = w_gnt0 | w_gnt1;
    assign w_sel_we    = w_gnt1 ? m1_we    : m0_we;
    assign w_sel_addr  = w_gnt1 ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_gnt1 ? m1_wdata : m0_wdata;

    // SRAM command register. It holds the accepted command for one cycle, otherwise idle.
    always_ff @(posedge clk) begin
        if (!rst_n || !w_acc) begin
            r_cen <= 1'b1;
            r_wen <= 1'b1;
            r_oen <= 1'b1;
            r_a   <= '0;
            r_d   <= '0;
        end else begin
            r_cen <= 1'b0;
            r_wen <= ~w_sel_we;
            r_oen <= w_sel_we;
            r_a   <= w_sel_addr;
            r_d   <= w_sel_we ? w_sel_wdata : '0;
        end
    end

    assign CEN      = r_cen;
    assign WEN      = r_wen;
    assign OEN      = r_oen;
    assign A        = r_a;
    assign Data2Mem = r_d;

    // Read-return valid pipeline. p1 holds the command on the pins; p2 holds the cycle the SRAM data is back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p1 <= w_acc & ~w_sel_we;
            r_vld_p2 <= r_vld_p1;
        end
    end

    // Owner tag that travels alongside the valid bits. Only meaningful while the matching valid is set.
    always_ff @(posedge clk) begin
        r_own_p1 <= w_gnt1;
        r_own_p2 <= r_own_p1;
    end

    assign w_rvalid0 = rst_n & r_vld_p2 & ~r_own_p2;
    assign w_rvalid1 = rst_n & r_vld_p2 &  r_own_p2;

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign m0_stall  = m0_req & ~w_gnt0;
    assign m1_stall  = m1_req & ~w_gnt1;
    assign m0_rvalid = w_rvalid0;
    assign m1_rvalid = w_rvalid1;
    assign m0_rdata  = w_rvalid0 ? ReadDataMem : '0;
    assign m1_rdata  = w_rvalid1 ? ReadDataMem : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by randomized traffic.
// A behavioural reference model predicts grants, SRAM pins and read returns,
// and an SRAM model sits behind the pins.

module tb_dmem_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_we, m0_gnt, m0_rvalid, m0_stall;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_gnt, m1_rvalid, m1_stall, m1_lock;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          CEN, WEN, OEN;
    logic [AW-1:0] A;
    logic [DW-1:0] Data2Mem, ReadDataMem;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_stall(m0_stall),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_stall(m1_stall),
        .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(Data2Mem),
        .ReadDataMem(ReadDataMem)
    );

    always #5 clk = ~clk;

    // Synchronous single-port SRAM. Read data is registered, so it appears the cycle after the command.
    logic [DW-1:0] sram [0:127];
    always @(posedge clk) begin
        if (!CEN) begin
            if (!WEN) sram[A] <= Data2Mem;
            else      ReadDataMem <= sram[A];
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        bit            mst;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          rq[$];
    logic [DW-1:0] shadow [0:127];
    bit            md_locked;
    int            md_last_master;   // master granted most recently
    bit            pins_known;
    bit            e_rd_cmd;
    logic          e_cen, e_wen, e_oen;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    bit            eg0, eg1;
    logic          obs_g0, obs_g1, obs_rv0, obs_rv1;
    int            cyc;
    int            total;
    int            passed;
    int            fails;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic void predict_grants();
        eg0 = 1'b0;
        eg1 = 1'b0;
        if (rst_n) begin
            if (md_locked) begin
                eg1 = m1_req;
            end else if (m0_req && m1_req) begin
                // the master not granted most recently wins
                if (md_last_master == 1) eg0 = 1'b1;
                else                     eg1 = 1'b1;
            end else begin
                eg0 = m0_req;
                eg1 = m1_req;
            end
        end
    endfunction

    task automatic tick();
        rsp_t          r;
        bit            e_rv0, e_rv1;
        logic [DW-1:0] e_rdat0, e_rdat1;
        bit            mst, we;
        int            addr;
        logic [DW-1:0] wd;
        @(negedge clk);
        predict_grants();
        obs_g0  = m0_gnt;
        obs_g1  = m1_gnt;
        obs_rv0 = m0_rvalid;
        obs_rv1 = m1_rvalid;
        chk("m0_gnt", m0_gnt, eg0);
        chk("m1_gnt", m1_gnt, eg1);
        chk("m0_stall", m0_stall, m0_req & ~eg0);
        chk("m1_stall", m1_stall, m1_req & ~eg1);
        if (pins_known) begin
            chk("CEN", CEN, e_cen);
            chk("WEN", WEN, e_wen);
            chk("OEN", OEN, e_oen);
            chk("A", A, e_a);
            if (!e_rd_cmd) chk("Data2Mem", Data2Mem, e_d);
        end
        e_rv0 = 1'b0; e_rv1 = 1'b0; e_rdat0 = '0; e_rdat1 = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            if (rst_n) begin
                if (r.mst) begin e_rv1 = 1'b1; e_rdat1 = r.data; end
                else       begin e_rv0 = 1'b1; e_rdat0 = r.data; end
            end
        end
        chk("m0_rvalid", m0_rvalid, e_rv0);
        chk("m1_rvalid", m1_rvalid, e_rv1);
        chk("m0_rdata", m0_rdata, e_rdat0);
        chk("m1_rdata", m1_rdata, e_rdat1);
        @(posedge clk);
        e_rd_cmd = 1'b0;
        e_cen = 1'b1; e_wen = 1'b1; e_oen = 1'b1; e_a = '0; e_d = '0;
        if (!rst_n) begin
            md_locked      = 1'b0;
            md_last_master = 1;
            rq.delete();
            pins_known     = 1'b1;
        end else begin
            if (eg0 || eg1) begin
                mst  = eg1;
                we   = mst ? m1_we : m0_we;
                addr = int'(mst ? m1_addr : m0_addr);
                wd   = mst ? m1_wdata : m0_wdata;
                md_last_master = mst ? 1 : 0;
                e_cen = 1'b0;
                e_a   = addr[AW-1:0];
                if (we) begin
                    e_wen = 1'b0;
                    e_d   = wd;
                    shadow[addr] = wd;
                end else begin
                    e_oen    = 1'b0;
                    e_rd_cmd = 1'b1;
                    rq.push_back('{due: cyc + 2, mst: mst, data: shadow[addr]});
                end
            end
            if (md_locked && !m1_lock) begin
                md_locked      = 1'b0;
                md_last_master = 1;
            end else if (!md_locked && eg1 && m1_lock) begin
                md_locked = 1'b1;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic set_m0(input bit req, input bit we, input int addr, input logic [DW-1:0] wd);
        m0_req = req; m0_we = we; m0_addr = addr[AW-1:0]; m0_wdata = wd;
    endtask

    task automatic set_m1(input bit req, input bit we, input int addr, input logic [DW-1:0] wd);
        m1_req = req; m1_we = we; m1_addr = addr[AW-1:0]; m1_wdata = wd;
    endtask

    task automatic idle_all();
        set_m0(0, 0, 0, '0);
        set_m1(0, 0, 0, '0);
        m1_lock = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] v;
        total = 0; passed = 0; fails = 0; cyc = 0;
        pins_known = 1'b0; e_rd_cmd = 1'b0;
        md_locked = 1'b0; md_last_master = 1;
        e_cen = 1'b1; e_wen = 1'b1; e_oen = 1'b1; e_a = '0; e_d = '0;
        for (int i = 0; i < 128; i++) begin
            v = $urandom;
            sram[i] = v;
            shadow[i] = v;
        end
        sram[5] = 32'hDEADBEEF;
        shadow[5] = 32'hDEADBEEF;

        // reset, with requests present in the second cycle: no grants, stall follows req
        rst_n = 1'b0;
        idle_all();
        tick();
        set_m0(1, 0, 3, '0);
        set_m1(1, 1, 4, 32'h1);
        tick();
        chk("rst_stall0", m0_stall, 1'b1);
        rst_n = 1'b1;
        idle_all();

        // three idle cycles: pins idle, no grants or returns
        repeat (3) tick();

        // m0 alone reads addr 5
        set_m0(1, 0, 5, '0);
        tick();
        chk("rd5_gnt", obs_g0, 1'b1);
        idle_all();
        tick();
        tick();
        chk("rd5_rvalid", obs_rv0, 1'b1);
        chk("rd5_m1_rvalid", obs_rv1, 1'b0);

        // reset, then both masters request every cycle: grants alternate m0, m1, ...
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_m0(1, 0, 1, '0);
        set_m1(1, 0, 2, '0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("alt_g0", obs_g0, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk("alt_g1", obs_g1, (i % 2 == 0) ? 1'b0 : 1'b1);
        end
        idle_all();
        tick();
        tick();

        // m1 writes addr 9, then m0 reads addr 9 on the next cycle
        set_m1(1, 1, 9, 32'h12345678);
        tick();
        idle_all();
        set_m0(1, 0, 9, '0);
        tick();
        idle_all();
        tick();
        tick();
        chk("raw_rvalid", obs_rv0, 1'b1);

        // lock: first make m0 the most recent grantee so that m1 wins contention
        set_m0(1, 0, 7, '0);
        tick();
        set_m1(1, 0, 8, '0);
        m1_lock = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lock_g1", obs_g1, 1'b1);
        end
        m1_lock = 1'b0;
        tick();
        tick();
        chk("unlock_g0", obs_g0, 1'b1);
        idle_all();
        tick();
        tick();
        tick();

        // reset lands in the cycle after a read is accepted: the read is dropped
        set_m0(1, 0, 5, '0);
        tick();
        idle_all();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_drop_rv0", obs_rv0, 1'b0);
        tick();

        // randomized traffic; a stalled requester holds its request
        for (int i = 0; i < 1500; i++) begin
            if (!(m0_req && !eg0)) begin
                set_m0($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15), $urandom);
            end
            if (!(m1_req && !eg1)) begin
                set_m1($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15), $urandom);
            end
            if ($urandom_range(0, 7) == 0) m1_lock = ~m1_lock;
            rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        rst_n = 1'b1;
        idle_all();
        repeat (4) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
